// File: rtl/mul_exec_unit.sv
// rtl/mul_exec_unit.sv - iterative shift-add RV32M multiply unit with CDB result handshake
// Optional feature: define MUL_RADIX4_EN to retire two multiplier bits per BUSY cycle.
module mul_exec_unit #(
  parameter int ROB_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mul_type,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  input  logic [ROB_DEPTH-1:0] rob_tag,
  input  logic                 flush,
  output logic                 ready,
  output logic                 result_valid,
  output logic [31:0]          result_f,
  output logic [ROB_DEPTH-1:0] result_rob,
  input  logic                 result_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_MUL    = 2'b00;
  localparam logic [1:0] TYPE_MULH   = 2'b01;
  localparam logic [1:0] TYPE_MULHSU = 2'b10;

`ifdef MUL_RADIX4_EN
  localparam int BITS_PER_STEP = 2;
`else
  localparam int BITS_PER_STEP = 1;
`endif
  localparam int         ITERS     = 32 / BITS_PER_STEP;
  localparam logic [5:0] ITERS_CNT = 6'(ITERS);

  state_t                 state;
  logic [63:0]            mcand;
  logic [31:0]            mplier;
  logic [63:0]            acc;
  logic [5:0]             cnt;
  logic                   neg_r;
  logic [1:0]             type_r;
  logic [ROB_DEPTH-1:0]   tag_r;

  logic                   a_neg;
  logic                   b_neg;
  logic [31:0]            a_mag;
  logic [31:0]            b_mag;
  logic [63:0]            pp;
  logic [63:0]            prod;
  logic [31:0]            fin;

  assign ready = (state == IDLE);

  // Operands are reduced to magnitudes up front; the sign is reapplied once at the end.
  always_comb begin
    a_neg = ((mul_type == TYPE_MULH) || (mul_type == TYPE_MULHSU)) && a[31];
    b_neg = (mul_type == TYPE_MULH) && b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
  end

  always_comb begin
    pp = mplier[0] ? mcand : 64'd0;
`ifdef MUL_RADIX4_EN
    if (mplier[1]) begin
      pp = pp + {mcand[62:0], 1'b0};
    end
`endif
  end

  always_comb begin
    prod = neg_r ? (64'd0 - acc) : acc;
    fin  = (type_r == TYPE_MUL) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mcand        <= 64'd0;
      mplier       <= 32'd0;
      acc          <= 64'd0;
      cnt          <= 6'd0;
      neg_r        <= 1'b0;
      type_r       <= 2'b00;
      tag_r        <= '0;
      result_valid <= 1'b0;
      result_f     <= 32'd0;
      result_rob   <= '0;
    end else if (flush) begin
      state        <= IDLE;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            acc    <= 64'd0;
            cnt    <= 6'd0;
            neg_r  <= a_neg ^ b_neg;
            type_r <= mul_type;
            tag_r  <= rob_tag;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == ITERS_CNT) begin
            result_f     <= fin;
            result_rob   <= tag_r;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            acc    <= acc + pp;
            mcand  <= mcand << BITS_PER_STEP;
            mplier <= mplier >> BITS_PER_STEP;
            cnt    <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_exec_unit.md
MUL_EXEC_UNIT -- requirements
Module: mul_exec_unit

Interface
REQ-001 The module SHALL have parameter ROB_DEPTH, default 3, giving the ROB tag width in bits.
REQ-002 The module SHALL have input clk, 1 bit, the single clock.
REQ-003 The module SHALL have input rst, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have input start, 1 bit, the request from the mul reservation station.
REQ-005 The module SHALL have input mul_type, 2 bits: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 The module SHALL have inputs a and b, 32 bits each: a is rs1, b is rs2.
REQ-007 The module SHALL have input rob_tag, ROB_DEPTH bits, the target ROB entry.
REQ-008 The module SHALL have input flush, 1 bit, which kills any in-flight operation.
REQ-009 The module SHALL have output ready, 1 bit: the unit can accept start.
REQ-010 The module SHALL have output result_valid, 1 bit: a result is offered to the CDB.
REQ-011 The module SHALL have output result_f, 32 bits, the selected result word.
REQ-012 The module SHALL have output result_rob, ROB_DEPTH bits, the tag of the result.
REQ-013 The module SHALL have input result_ack, 1 bit, the CDB grant for the offered result.

Function
REQ-014 The unit SHALL be a 3-state FSM (IDLE, BUSY, DONE) with ready equal to (state==IDLE).
REQ-015 The unit SHALL accept an operation on an edge where start&&ready&&!flush, and SHALL latch a, b, mul_type and rob_tag on that edge; later changes on these inputs SHALL have no effect.
REQ-016 The unit SHALL ignore start while ready=0, with no state change.
REQ-017 In BUSY the unit SHALL perform one shift-add iteration per edge on |a'| and |b'| (unsigned magnitudes), consuming 1 multiplier bit per edge, 32 iterations in total.
REQ-018 Signedness SHALL be: MUL and MULHU treat both operands as unsigned; MULH treats both as signed; MULHSU treats a as signed and b as unsigned.
REQ-019 The 64-bit product SHALL be two's-complement negated at the end iff exactly one operand was treated as negative.
REQ-020 result_f SHALL be product[31:0] for MUL and product[63:32] for the other three types.
REQ-021 Latency: accept on edge 0, iterations on edges 1..32, sign fix and BUSY->DONE on edge 33; result_valid SHALL be 1 starting after edge 33.
REQ-022 In DONE, result_valid, result_f and result_rob SHALL be held stable until an edge with result_ack=1, after which the state SHALL be IDLE.
REQ-023 result_ack while result_valid=0 SHALL be ignored.
REQ-024 Flush SHALL force IDLE on the next edge from any state, drop any pending result and ignore a simultaneous start (flush wins).
REQ-025 Operands of 0 SHALL yield 0 with no sign artifacts, e.g. MULH 0 x 0x80000000 gives 0.

Reset
REQ-026 On rst the state SHALL be IDLE, with ready=1, result_valid=0, result_f=0, result_rob=0 and all internal accumulators cleared.
REQ-027 rst SHALL abort an operation mid-flight with no result emitted; rst SHALL have priority over flush and start.

Configuration
REQ-028 When the macro MUL_RADIX4_EN is defined, BUSY SHALL consume 2 multiplier bits per edge (16 iterations), so DONE is entered on edge 17.
REQ-029 When MUL_RADIX4_EN is undefined, the unit SHALL behave as in REQ-017 and REQ-021 (33-cycle latency).
REQ-030 The numeric results and handshakes SHALL be identical in both configurations.

Verification
REQ-031 Scenario 1: MUL a=7, b=6, rob_tag=5, result_ack tied 1 -> result_valid after edge 33 (edge 17 with radix-4), result_f=42, result_rob=5, ready=1 on the following cycle.
REQ-032 Scenario 2: a=0xFFFFFFFF, b=2 -> MULH result_f=0xFFFFFFFF; MULHU result_f=0x00000001; MUL result_f=0xFFFFFFFE.
REQ-033 Scenario 3: MULHSU a=0x80000000, b=0xFFFFFFFF -> result_f=0x80000000; MULH with the same operands -> result_f=0x00000000.
REQ-034 Scenario 4: result_ack held 0 for 10 cycles in DONE, start pulsed -> result_valid, result_f and result_rob stable, ready=0, start ignored; ack -> IDLE.
REQ-035 Scenario 5: flush on edge 10 of BUSY, same cycle as start -> ready=1 after that edge, no result_valid ever; a new MUL 3x3 then returns 9.
REQ-036 Scenario 6: rst asserted on edge 20 of BUSY -> all outputs at reset values on the next cycle, no result; a subsequent MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result_f=0xFFFFFFFE.
